// File: rtl/nw_align_engine.sv
// Needleman-Wunsch global aligner: fills the DP matrix one cell per cycle using a single
// score row plus a 2-bit direction store, then streams the traceback path over ready/valid.
module nw_align_engine #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned CWIDTH  = 2,
  parameter int unsigned SWIDTH  = 16,
  parameter int unsigned WWIDTH  = 8,
  parameter int unsigned LWIDTH  = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_valid,
  output logic                        start_ready,
  input  logic [MAX_LEN*CWIDTH-1:0]   s1,
  input  logic [MAX_LEN*CWIDTH-1:0]   s2,
  input  logic [LWIDTH-1:0]           len1,
  input  logic [LWIDTH-1:0]           len2,
  input  logic signed [WWIDTH-1:0]    w_match,
  input  logic signed [WWIDTH-1:0]    w_mismatch,
  input  logic signed [WWIDTH-1:0]    w_gap,
  output logic                        busy,
  output logic                        err,
  output logic signed [SWIDTH-1:0]    score,
  output logic                        score_valid,
  output logic                        tb_valid,
  input  logic                        tb_ready,
  output logic [1:0]                  tb_op,
  output logic [LWIDTH-1:0]           tb_i,
  output logic [LWIDTH-1:0]           tb_j,
  output logic                        tb_last,
  output logic                        done
);

  localparam int unsigned DEPTH = MAX_LEN * MAX_LEN;
  localparam int unsigned DAW   = $clog2(DEPTH);
  localparam int unsigned SLW   = MAX_LEN * CWIDTH;
  localparam logic [1:0] OP_DIAG = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_LEFT = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_TRACE, S_FINISH} state_e;

  state_e                    state_q, state_d;
  logic [SLW-1:0]            s1_q, s1_d, s2_q, s2_d;
  logic [LWIDTH-1:0]         len1_q, len1_d, len2_q, len2_d;
  logic signed [SWIDTH-1:0]  wm_q, wm_d, wx_q, wx_d, wg_q, wg_d;
  logic [LWIDTH-1:0]         i_q, i_d, j_q, j_d;
  logic signed [SWIDTH-1:0]  diag_q, diag_d, left_q, left_d, edge_q, edge_d;
  logic signed [SWIDTH-1:0]  score_q, score_d;
  logic                      score_valid_q, score_valid_d;
  logic                      start_ready_q, start_ready_d;
  logic                      busy_q, busy_d, err_q, err_d, done_q, done_d;
  logic                      tb_valid_q, tb_valid_d, tb_last_q, tb_last_d;
  logic [1:0]                tb_op_q, tb_op_d;
  logic [LWIDTH-1:0]         tb_i_q, tb_i_d, tb_j_q, tb_j_d;

  logic signed [SWIDTH-1:0]  row_q [MAX_LEN+1];
  logic [1:0]                dir_q [DEPTH];

  logic                      row_init_c, row_we_c, dir_we_c;
  logic signed [SWIDTH-1:0]  gap_in_c;
  logic [CWIDTH-1:0]         c1_c, c2_c;
  logic signed [SWIDTH-1:0]  sub_c, v_diag_c, v_up_c, v_left_c, best_c;
  logic [1:0]                cell_dir_c;
  logic [DAW-1:0]            cell_addr_c, ent_addr_c;
  logic [LWIDTH-1:0]         ent_i_c, ent_j_c;
  logic                      ent_byp_c, ent_last_c;
  logic [1:0]                ent_op_c;

  assign gap_in_c = SWIDTH'(w_gap);

  // Current cell: score candidates and deterministic DIAG > UP > LEFT tie-break
  always_comb begin
    c1_c        = CWIDTH'(s1_q >> (CWIDTH * (int'(i_q) - 1)));
    c2_c        = CWIDTH'(s2_q >> (CWIDTH * (int'(j_q) - 1)));
    sub_c       = (c1_c == c2_c) ? wm_q : wx_q;
    v_diag_c    = diag_q + sub_c;
    v_up_c      = row_q[j_q] + wg_q;
    v_left_c    = left_q + wg_q;
    cell_addr_c = DAW'(int'(i_q) * int'(MAX_LEN) - int'(MAX_LEN) + int'(j_q) - 1);
    if (v_diag_c >= v_up_c && v_diag_c >= v_left_c) begin
      best_c     = v_diag_c;
      cell_dir_c = OP_DIAG;
    end else if (v_up_c >= v_left_c) begin
      best_c     = v_up_c;
      cell_dir_c = OP_UP;
    end else begin
      best_c     = v_left_c;
      cell_dir_c = OP_LEFT;
    end
  end

  // Coordinates of the next traceback entry to present
  always_comb begin
    ent_i_c   = tb_i_q - LWIDTH'(tb_op_q != OP_LEFT);
    ent_j_c   = tb_j_q - LWIDTH'(tb_op_q != OP_UP);
    ent_byp_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        ent_i_c = len1;
        ent_j_c = len2;
      end
      S_FILL: begin
        ent_i_c   = len1_q;
        ent_j_c   = len2_q;
        ent_byp_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Move at the selected cell; the final cell's direction bypasses the store
  always_comb begin
    ent_addr_c = DAW'(int'(ent_i_c) * int'(MAX_LEN) - int'(MAX_LEN) + int'(ent_j_c) - 1);
    if (ent_j_c == '0)      ent_op_c = OP_UP;
    else if (ent_i_c == '0) ent_op_c = OP_LEFT;
    else if (ent_byp_c)     ent_op_c = cell_dir_c;
    else                    ent_op_c = dir_q[ent_addr_c];
    ent_last_c = (ent_op_c == OP_DIAG && ent_i_c == LWIDTH'(1) && ent_j_c == LWIDTH'(1)) ||
                 (ent_op_c == OP_UP   && ent_i_c == LWIDTH'(1) && ent_j_c == '0) ||
                 (ent_op_c == OP_LEFT && ent_i_c == '0 && ent_j_c == LWIDTH'(1));
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    s1_d          = s1_q;
    s2_d          = s2_q;
    len1_d        = len1_q;
    len2_d        = len2_q;
    wm_d          = wm_q;
    wx_d          = wx_q;
    wg_d          = wg_q;
    i_d           = i_q;
    j_d           = j_q;
    diag_d        = diag_q;
    left_d        = left_q;
    edge_d        = edge_q;
    score_d       = score_q;
    score_valid_d = score_valid_q;
    tb_valid_d    = tb_valid_q;
    tb_op_d       = tb_op_q;
    tb_i_d        = tb_i_q;
    tb_j_d        = tb_j_q;
    tb_last_d     = tb_last_q;
    err_d         = 1'b0;
    row_init_c    = 1'b0;
    row_we_c      = 1'b0;
    dir_we_c      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          s1_d          = s1;
          s2_d          = s2;
          len1_d        = len1;
          len2_d        = len2;
          wm_d          = SWIDTH'(w_match);
          wx_d          = SWIDTH'(w_mismatch);
          wg_d          = gap_in_c;
          score_valid_d = 1'b0;
          if (len1 > LWIDTH'(MAX_LEN) || len2 > LWIDTH'(MAX_LEN)) begin
            err_d = 1'b1;
          end else if (len1 == '0 || len2 == '0) begin
            score_d       = $signed(SWIDTH'(len1) + SWIDTH'(len2)) * gap_in_c;
            score_valid_d = 1'b1;
            if (len1 == '0 && len2 == '0) begin
              state_d = S_FINISH;
            end else begin
              state_d    = S_TRACE;
              tb_valid_d = 1'b1;
              tb_op_d    = ent_op_c;
              tb_i_d     = len1;
              tb_j_d     = len2;
              tb_last_d  = ent_last_c;
            end
          end else begin
            state_d    = S_FILL;
            i_d        = LWIDTH'(1);
            j_d        = LWIDTH'(1);
            diag_d     = '0;
            left_d     = gap_in_c;
            edge_d     = gap_in_c;
            row_init_c = 1'b1;
          end
        end
      end
      S_FILL: begin
        row_we_c = 1'b1;
        dir_we_c = 1'b1;
        if (j_q == len2_q) begin
          if (i_q == len1_q) begin
            state_d       = S_TRACE;
            score_d       = best_c;
            score_valid_d = 1'b1;
            tb_valid_d    = 1'b1;
            tb_op_d       = ent_op_c;
            tb_i_d        = len1_q;
            tb_j_d        = len2_q;
            tb_last_d     = ent_last_c;
          end else begin
            i_d    = i_q + LWIDTH'(1);
            j_d    = LWIDTH'(1);
            diag_d = edge_q;
            left_d = edge_q + wg_q;
            edge_d = edge_q + wg_q;
          end
        end else begin
          j_d    = j_q + LWIDTH'(1);
          diag_d = row_q[j_q];
          left_d = best_c;
        end
      end
      S_TRACE: begin
        if (tb_ready) begin
          if (tb_last_q) begin
            state_d    = S_FINISH;
            tb_valid_d = 1'b0;
          end else begin
            tb_op_d   = ent_op_c;
            tb_i_d    = ent_i_c;
            tb_j_d    = ent_j_c;
            tb_last_d = ent_last_c;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    start_ready_d = (state_d == S_IDLE);
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_FINISH);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      s1_q          <= '0;
      s2_q          <= '0;
      len1_q        <= '0;
      len2_q        <= '0;
      wm_q          <= '0;
      wx_q          <= '0;
      wg_q          <= '0;
      i_q           <= '0;
      j_q           <= '0;
      diag_q        <= '0;
      left_q        <= '0;
      edge_q        <= '0;
      score_q       <= '0;
      score_valid_q <= 1'b0;
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      done_q        <= 1'b0;
      tb_valid_q    <= 1'b0;
      tb_op_q       <= '0;
      tb_i_q        <= '0;
      tb_j_q        <= '0;
      tb_last_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      len1_q        <= len1_d;
      len2_q        <= len2_d;
      wm_q          <= wm_d;
      wx_q          <= wx_d;
      wg_q          <= wg_d;
      i_q           <= i_d;
      j_q           <= j_d;
      diag_q        <= diag_d;
      left_q        <= left_d;
      edge_q        <= edge_d;
      score_q       <= score_d;
      score_valid_q <= score_valid_d;
      start_ready_q <= start_ready_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
      done_q        <= done_d;
      tb_valid_q    <= tb_valid_d;
      tb_op_q       <= tb_op_d;
      tb_i_q        <= tb_i_d;
      tb_j_q        <= tb_j_d;
      tb_last_q     <= tb_last_d;
    end
  end

  // Score row (H[i-1][*] ahead of column j, H[i][*] behind it) and direction store
  always_ff @(posedge clk) begin
    if (row_init_c) begin
      for (int k = 0; k <= int'(MAX_LEN); k++) row_q[k] <= SWIDTH'(k) * gap_in_c;
    end else if (row_we_c) begin
      row_q[j_q] <= best_c;
    end
    if (dir_we_c) dir_q[cell_addr_c] <= cell_dir_c;
  end

  assign start_ready = start_ready_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign score       = score_q;
  assign score_valid = score_valid_q;
  assign tb_valid    = tb_valid_q;
  assign tb_op       = tb_op_q;
  assign tb_i        = tb_i_q;
  assign tb_j        = tb_j_q;
  assign tb_last     = tb_last_q;
  assign done        = done_q;

endmodule
